// File: rtl/fir.sv
// fir: 15-tap direct-form low-pass FIR with per-tap product truncation,
// floor output quantisation and symmetric saturation. Latency 2 edges.
`default_nettype none

module fir #(
  parameter int COE_INTE_WL = 4,
  parameter int COE_FRAC_WL = 8,
  parameter int IN_INTE_WL  = 4,
  parameter int IN_FRAC_WL  = 8,
  parameter int OUT_INTE_WL = 4,
  parameter int OUT_FRAC_WL = 8,
  parameter int PRODUCT_FRAC_WL_ARRAY [0:14] = '{9, 15, 11, 12, 9, 14, 10, 8, 9, 13, 12, 9, 8, 9, 12}
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic signed [IN_INTE_WL-1:-IN_FRAC_WL]    data_in,
  input  logic                                      in_valid,
  output logic signed [OUT_INTE_WL-1:-OUT_FRAC_WL]  data_out,
  output logic                                      out_valid
);

  localparam int TAPS      = 15;
  localparam int COE_W     = COE_INTE_WL + COE_FRAC_WL;
  localparam int IN_W      = IN_INTE_WL + IN_FRAC_WL;
  localparam int OUT_W     = OUT_INTE_WL + OUT_FRAC_WL;
  localparam int PROD_W    = COE_W + IN_W;
  localparam int PROD_FRAC = COE_FRAC_WL + IN_FRAC_WL;
  localparam int ACC_W     = COE_INTE_WL + IN_INTE_WL + 4 + PROD_FRAC;
  localparam int FRAC_DROP = PROD_FRAC - OUT_FRAC_WL;

  // Prototype coefficients in units of 2^-8.
  localparam int C256 [0:TAPS-1] = '{-1, -3, 0, 8, 20, 34, 46, 48, 46, 34, 20, 8, 0, -3, -1};

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic int coef_raw(input int k);
    if (COE_FRAC_WL >= 8)
      return C256[k] * (1 << (COE_FRAC_WL - 8));
    else
      return (C256[k] + (1 << (7 - COE_FRAC_WL))) >>> (8 - COE_FRAC_WL);
  endfunction

  logic signed [IN_W-1:0]   line [0:TAPS-1];
  logic signed [ACC_W-1:0]  term [0:TAPS-1];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_shift;
  logic signed [OUT_W-1:0]  out_q;
  logic                     valid_d1;

  generate
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
      localparam logic signed [COE_W-1:0] H = COE_W'(coef_raw(k));
      localparam int DROP = PROD_FRAC - PRODUCT_FRAC_WL_ARRAY[k];
      logic signed [PROD_W-1:0] prod;
      logic signed [PROD_W-1:0] prod_t;
      assign prod   = line[k] * H;
      // Arithmetic shift down then back up clears the LSBs, i.e. floors.
      assign prod_t = (prod >>> DROP) <<< DROP;
      assign term[k] = {{(ACC_W-PROD_W){prod_t[PROD_W-1]}}, prod_t};
    end
  endgenerate

  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++)
      acc = acc + term[k];
  end

  assign acc_shift = acc >>> FRAC_DROP;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++)
        line[k] <= '0;
      valid_d1  <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else begin
      if (in_valid) begin
        line[0] <= data_in;
        for (int k = 1; k < TAPS; k++)
          line[k] <= line[k-1];
      end
      valid_d1  <= in_valid;
      out_valid <= valid_d1;
      // Output is taken from the line before this edge's shift.
      if (valid_d1) begin
        if (acc_shift > SAT_MAX)
          out_q <= SAT_MAX[OUT_W-1:0];
        else if (acc_shift < SAT_MIN)
          out_q <= SAT_MIN[OUT_W-1:0];
        else
          out_q <= acc_shift[OUT_W-1:0];
      end
    end
  end

  assign data_out = out_q;

endmodule

`default_nettype wire

// File: tb/tb_fir.sv
// tb_fir: randomized and directed stimulus checked against an integer
// arithmetic reference model of the filter.
`default_nettype none

module tb_fir;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid;
  logic              out_valid;
  logic signed [3:-8] data_in;
  logic signed [3:-8] data_out;

  fir dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .in_valid (in_valid),
    .data_out (data_out),
    .out_valid(out_valid)
  );

  int vectors = 0;
  int errors  = 0;

  int coef [0:14] = '{-1, -3, 0, 8, 20, 34, 46, 48, 46, 34, 20, 8, 0, -3, -1};
  int pfw  [0:14] = '{9, 15, 11, 12, 9, 14, 10, 8, 9, 13, 12, 9, 8, 9, 12};

  // Reference state: accepted-sample history and expected outputs.
  int hist [0:14];
  bit v_d1;
  bit ov_exp;
  int do_exp;

  task automatic check(input string tag, input integer got, input integer exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint floor_pow2(input longint a, input int d);
    longint div = longint'(1) << d;
    longint q   = a / div;
    if (a < 0 && q * div != a) q = q - 1;
    return q;
  endfunction

  function automatic int model_y();
    longint sum = 0;
    longint p;
    longint y;
    for (int k = 0; k < 15; k++) begin
      p = longint'(hist[k]) * coef[k];                 // units of 2^-16
      sum += floor_pow2(p, 16 - pfw[k]) * (longint'(1) << (16 - pfw[k]));
    end
    y = floor_pow2(sum, 8);                            // units of 2^-8
    if (y > 2047)  y = 2047;
    if (y < -2048) y = -2048;
    return int'(y);
  endfunction

  task automatic cyc(input bit r, input bit v, input int d);
    rst      = r;
    in_valid = v;
    data_in  = 12'(d);
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 15; k++) hist[k] = 0;
      v_d1   = 1'b0;
      ov_exp = 1'b0;
      do_exp = 0;
    end else begin
      ov_exp = v_d1;
      if (v_d1) do_exp = model_y();
      if (v) begin
        for (int k = 14; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = d;
      end
      v_d1 = v;
    end
    #1;
    check("out_valid", out_valid, ov_exp);
    check("data_out", $signed(data_out), do_exp);
  endtask

  task automatic send_sat(input bit invert);
    int s;
    for (int j = 0; j < 15; j++) begin
      s = (coef[14-j] < 0) ? -2048 : 2047;
      if (invert) s = (coef[14-j] < 0) ? 2047 : -2048;
      cyc(1'b0, 1'b1, s);
    end
    cyc(1'b0, 1'b0, 0);
  endtask

  initial begin
    for (int k = 0; k < 15; k++) hist[k] = 0;
    v_d1 = 1'b0; ov_exp = 1'b0; do_exp = 0;

    // Reset held with random inputs.
    for (int i = 0; i < 15; i++)
      cyc(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)) - 2048);

    // Impulse of 1.0 then zeros.
    cyc(1'b0, 1'b1, 256);
    for (int i = 0; i < 18; i++) cyc(1'b0, 1'b1, 0);

    // Smallest impulse: product truncation on negative taps.
    cyc(1'b0, 1'b1, 1);
    cyc(1'b0, 1'b1, 0);
    cyc(1'b0, 1'b1, 0);
    check("trunc_tap0", $signed(data_out), -1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 0);

    // DC step from fresh reset.
    cyc(1'b1, 1'b0, 0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 256);
    cyc(1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 0);
    check("dc_final", $signed(data_out), 256);

    // Saturation both directions.
    send_sat(1'b0);
    check("sat_hi", $signed(data_out), 2047);
    send_sat(1'b1);
    check("sat_lo", $signed(data_out), -2048);

    // Valid gap pattern 1,1,0,1,0,0,1.
    begin
      bit pat [0:6] = '{1, 1, 0, 1, 0, 0, 1};
      for (int i = 0; i < 7; i++)
        cyc(1'b0, pat[i], int'($urandom_range(0, 511)) - 256);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 0);
    end

    // Random stream with gaps and occasional mid-stream reset.
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 70,
          int'($urandom_range(0, 4095)) - 2048);
    for (int i = 0; i < 300; i++)
      cyc(1'b0, $urandom_range(0, 99) < 80, int'($urandom_range(0, 511)) - 256);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fir.md
# fir

Fixed-coefficient 15-tap direct-form FIR low-pass filter for the word-length-optimisation flow. Accepts one signed fixed-point sample per valid cycle and produces one filtered sample per accepted input. Each of the 15 partial products is truncated to its own fractional word length (PRODUCT_FRAC_WL_ARRAY), so the optimiser can trade accuracy against area per tap.

## Interface
- COE_INTE_WL, 4, coefficient integer bits (incl. sign)
- COE_FRAC_WL, 8, coefficient fractional bits
- IN_INTE_WL, 4, input integer bits (incl. sign)
- IN_FRAC_WL, 8, input fractional bits
- OUT_INTE_WL, 4, output integer bits (incl. sign)
- OUT_FRAC_WL, 8, output fractional bits
- PRODUCT_FRAC_WL_ARRAY, int [0:14], {9,15,11,12,9,14,10,8,9,13,12,9,8,9,12}, fractional bits kept for product of tap k; each entry must be ≤ COE_FRAC_WL+IN_FRAC_WL
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  signed [IN_INTE_WL-1:-IN_FRAC_WL]  input sample
- in_valid  in  1  data_in valid this cycle
- data_out  out  signed [OUT_INTE_WL-1:-OUT_FRAC_WL]  filtered sample
- out_valid  out  1  data_out valid this cycle

## Operation
- Coefficients c[0..14] = {-1,-3,0,8,20,34,46,48,46,34,20,8,0,-3,-1}/256 (symmetric, DC gain 1.0); stored as h[k] = round(c[k]·2^COE_FRAC_WL), signed COE_INTE_WL+COE_FRAC_WL bits. Defaults give raw h = c·256.
- Delay line x[0..14], IN width, all zero after reset. On a clock edge with in_valid=1: x[0]←data_in, x[k]←x[k-1]. With in_valid=0 the line holds.
- y = Σ_k P_k, P_k = x[k]·h[k] (full precision, COE_FRAC_WL+IN_FRAC_WL fractional bits) truncated toward −∞ (drop LSBs, two's-complement floor) to PRODUCT_FRAC_WL_ARRAY[k] fractional bits.
- Accumulator: COE_FRAC_WL+IN_FRAC_WL fractional bits (truncated products zero-padded), COE_INTE_WL+IN_INTE_WL+4 integer bits; no internal overflow.
- Output quantisation: floor to OUT_FRAC_WL fractional bits, then saturate to [−2^(OUT_INTE_WL−1), 2^(OUT_INTE_WL−1) − 2^−OUT_FRAC_WL] (defaults: raw −2048..2047).
- One output per accepted input; no outputs without input.

## Timing
- Reset (rst=1 at edge): delay line 0, valid pipeline 0, out_valid=0, data_out=0. Reset mid-stream discards all in-flight samples and history; first input after reset sees zero history.
- Latency 2 cycles: sample accepted at edge t (in_valid=1) shifts into the line; at edge t+1 data_out registers y computed from the line including that sample, and out_valid=1 for that cycle.
- out_valid is in_valid delayed 2 edges exactly; gaps in in_valid reproduce as identical gaps in out_valid.
- When out_valid=0, data_out holds its last value.
- No backpressure; block accepts a sample every cycle.

## Test plan
- Reset: hold rst 15 cycles with random data_in/in_valid → out_valid=0, data_out=0 throughout; first input after release behaves as zero history.
- Impulse: data_in raw 256 (1.0) one cycle, then 15+ cycles raw 0, in_valid continuous → data_out raw −1,−3,0,8,20,34,46,48,46,34,20,8,0,−3,−1 then 0; first output 2 cycles after impulse.
- Product truncation: impulse raw 1 (2^−8) then zeros → data_out raw −1 on outputs 0,1,13,14 (negative taps floor), 0 on all others.
- DC step: constant raw 256 for 20 cycles → outputs ramp via partial sums to raw 256 from output 14 onward.
- Saturation: full-scale input signs aligned to coefficient signs (x=−2048 on negative taps, 2047 elsewhere) → data_out raw 2047; inverted pattern → raw −2048.
- Valid gaps: in_valid pattern 1,1,0,1,0,0,1 → out_valid same pattern delayed 2 cycles; results equal the gap-free stream; data_out stable during gaps.
